tone_generator_tdm: RTL
=======================

TONE_GENERATOR_TDM -- requirements
Module: tone_generator_tdm

Interface
REQ-001 SHALL have parameter VOICES, default 4: number of time-multiplexed voices (2..16).
REQ-002 SHALL have parameter FREQ_BITS, default 16: per-voice phase increment width.
REQ-003 SHALL have parameter PULSEWIDTH_BITS, default 12: pulse-width compare width (≤ ACCUMULATOR_BITS).
REQ-004 SHALL have parameter OUTPUT_BITS, default 12: sample width (≤ 23).
REQ-005 SHALL have parameter ACCUMULATOR_BITS, default 24: phase accumulator width.
REQ-006 SHALL have port main_clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port sample_strobe  input  1  one-cycle pulse starting a frame.
REQ-009 SHALL have port cfg_wr  input  1  configuration write enable.
REQ-010 SHALL have port cfg_voice  input  $clog2(VOICES)  voice addressed by the write.
REQ-011 SHALL have port cfg_freq  input  FREQ_BITS  phase increment.
REQ-012 SHALL have port cfg_pw  input  PULSEWIDTH_BITS  pulse width.
REQ-013 SHALL have port cfg_wave  input  4  enables {noise,pulse,triangle,saw}, bits 3..0.
REQ-014 SHALL have port cfg_sync, cfg_ringmod  input  1 each  hard-sync and ring-mod enables.
REQ-015 SHALL have port busy  output  1  frame scan in progress.
REQ-016 SHALL have port dout_valid  output  1  dout/dout_voice qualifier.
REQ-017 SHALL have port dout_voice  output  $clog2(VOICES)  voice index of dout.
REQ-018 SHALL have port dout  output  OUTPUT_BITS  voice sample.

Function
REQ-019 SHALL implement FSM IDLE→SCAN on sample_strobe in IDLE; SCAN advances voice index 0..VOICES-1 one per cycle; IDLE after last voice; busy=1 exactly in SCAN.
REQ-020 SHALL ignore sample_strobe while busy=1 (no queueing).
REQ-021 SHALL, for voice v in SCAN, update acc[v] <= acc[v][A-1:0] + freq[v], retaining carry bit A as ovf[v].
REQ-022 SHALL set acc[v] <= 0 instead when sync[v]=1 and ovf of source voice (v-1) mod VOICES is 1; source for v>0 is this frame's value, for v=0 the previous frame's value.
REQ-023 SHALL compute waveforms from updated acc (A=ACCUMULATOR_BITS, O=OUTPUT_BITS): saw=acc[A-1 -: O]; triangle=(acc[A-1]^rm)?~acc[A-2 -: O]:acc[A-2 -: O], rm=ringmod[v]&MSB of source voice; pulse=all-ones when acc[A-1 -: PULSEWIDTH_BITS] ≥ pw[v], else 0.
REQ-024 SHALL output dout = AND of enabled waveforms; dout=0 when cfg_wave=0.
REQ-025 SHALL register dout: voice v valid 2 cycles after the cycle it is selected; frame strobed at cycle 0 yields dout_valid in cycles 2..VOICES+1, dout_voice ascending.
REQ-026 SHALL apply cfg_wr at the next edge; a voice updated in the same cycle uses its old configuration.
REQ-027 SHALL leave accumulators unchanged outside SCAN.

Reset
REQ-028 SHALL, with rst=1 at an edge, clear all acc, ovf, configuration registers, dout, dout_voice, dout_valid, busy; FSM to IDLE; LFSRs to 23'h7FFFFF.
REQ-029 SHALL abort a scan in progress on reset, dout_valid low from the next cycle; reset dominates sample_strobe and cfg_wr.

Configuration
REQ-030 SHALL, with TONE_GENERATOR_TDM_NOISE_EN defined, give each voice a 23-bit Fibonacci LFSR (taps 23,18) stepped when acc[v] bit A-5 rises across its update; noise=LFSR[22 -: O] ANDed in when cfg_wave[3]=1.
REQ-031 SHALL, without TONE_GENERATOR_TDM_NOISE_EN, omit LFSRs and ignore cfg_wave[3].

Verification (VOICES=4, defaults)
REQ-032 Timing: strobe cycle 0 → busy cycles 1..4, dout_valid cycles 2..5, dout_voice 0,1,2,3; strobe cycle 3 ignored.
REQ-033 Saw: voice0 freq 16'h1000, wave 4'b0001, 16 frames → dout 12'h001..12'h010, frame n = n.
REQ-034 Pulse: voice2 freq 16'hFFFF, pw 12'h800, wave 4'b0100 → dout 0 while acc<24'h800000, 12'hFFF from first frame acc[23]=1.
REQ-035 Sync: voice0 freq 16'hFFFF overflows at frame 257; voice1 freq 16'h0100, sync=1 → voice1 dout 12'h000 in frame 257, continues from 0.
REQ-036 Reset mid-scan at cycle 3 → dout_valid 0 next cycle, next frame voice0 saw = 12'h001 with freq 16'h1000.
REQ-037 Noise: macro defined, wave 4'b1000, freq 16'hFFFF → dout non-constant across 64 frames; macro undefined → dout 0.

Source files
------------

// File: rtl/tone_generator_tdm.sv
// Time-multiplexed tone generator: one voice processed per cycle during a frame scan.
// Optional per-voice LFSR noise source enabled by defining TONE_GENERATOR_TDM_NOISE_EN.
module tone_generator_tdm #(
    parameter int unsigned VOICES           = 4,
    parameter int unsigned FREQ_BITS        = 16,
    parameter int unsigned PULSEWIDTH_BITS  = 12,
    parameter int unsigned OUTPUT_BITS      = 12,
    parameter int unsigned ACCUMULATOR_BITS = 24
) (
    input  logic                          main_clk,
    input  logic                          rst,
    input  logic                          sample_strobe,
    input  logic                          cfg_wr,
    input  logic [$clog2(VOICES)-1:0]     cfg_voice,
    input  logic [FREQ_BITS-1:0]          cfg_freq,
    input  logic [PULSEWIDTH_BITS-1:0]    cfg_pw,
    input  logic [3:0]                    cfg_wave,
    input  logic                          cfg_sync,
    input  logic                          cfg_ringmod,
    output logic                          busy,
    output logic                          dout_valid,
    output logic [$clog2(VOICES)-1:0]     dout_voice,
    output logic [OUTPUT_BITS-1:0]        dout
);
    localparam int unsigned VW = $clog2(VOICES);
    localparam int unsigned A  = ACCUMULATOR_BITS;
    localparam int unsigned O  = OUTPUT_BITS;
    localparam int unsigned PW = PULSEWIDTH_BITS;
    localparam logic [VW-1:0] LAST = VW'(VOICES - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   idx_q, idx_d;

    logic [FREQ_BITS-1:0] freq_q    [VOICES];
    logic [PW-1:0]        pw_q      [VOICES];
    logic [2:0]           wave_q    [VOICES];
    logic                 sync_q    [VOICES];
    logic                 ringmod_q [VOICES];
    logic [A-1:0]         acc_q     [VOICES];
    logic                 ovf_q     [VOICES];

    logic [O-1:0]  dout_q;
    logic [VW-1:0] voice_q;
    logic          valid_q;

    logic [VW-1:0] src;
    logic [A:0]    sum;
    logic [A-1:0]  acc_d;
    logic          rm;
    logic [O-1:0]  saw, tri_w, pulse, sample_d;
    logic          any_en;

`ifdef TONE_GENERATOR_TDM_NOISE_EN
    logic [22:0] lfsr_q [VOICES];
    logic [22:0] lfsr_d;
    logic        noise_en_q [VOICES];
`else
    logic        unused_noise_sel;
    assign unused_noise_sel = cfg_wave[3];
`endif

    // State register
    always_ff @(posedge main_clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; strobes arriving during SCAN are dropped
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (sample_strobe) begin
                state_d = SCAN;
                idx_d   = '0;
            end
            SCAN: if (idx_q == LAST) state_d = IDLE;
                  else               idx_d   = idx_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb busy = (state_q == SCAN);

    // Source voice: for v>0 already updated this frame, for v=0 still holds last frame's value
    always_comb begin
        src    = (idx_q == '0) ? LAST : idx_q - 1'b1;
        sum    = {1'b0, acc_q[idx_q]} + (A+1)'(freq_q[idx_q]);
        acc_d  = (sync_q[idx_q] && ovf_q[src]) ? '0 : sum[A-1:0];
        rm     = ringmod_q[idx_q] & acc_q[src][A-1];
        saw    = acc_d[A-1 -: O];
        tri_w  = (acc_d[A-1] ^ rm) ? ~acc_d[A-2 -: O] : acc_d[A-2 -: O];
        pulse  = (acc_d[A-1 -: PW] >= pw_q[idx_q]) ? '1 : '0;
`ifdef TONE_GENERATOR_TDM_NOISE_EN
        lfsr_d = lfsr_q[idx_q];
        if (!acc_q[idx_q][A-5] && acc_d[A-5])
            lfsr_d = {lfsr_q[idx_q][0] ^ lfsr_q[idx_q][5], lfsr_q[idx_q][22:1]};
`endif
        sample_d = '1;
        any_en   = 1'b0;
        if (wave_q[idx_q][0]) begin sample_d = sample_d & saw;   any_en = 1'b1; end
        if (wave_q[idx_q][1]) begin sample_d = sample_d & tri_w; any_en = 1'b1; end
        if (wave_q[idx_q][2]) begin sample_d = sample_d & pulse; any_en = 1'b1; end
`ifdef TONE_GENERATOR_TDM_NOISE_EN
        if (noise_en_q[idx_q]) begin sample_d = sample_d & lfsr_d[22 -: O]; any_en = 1'b1; end
`endif
        if (!any_en) sample_d = '0;
    end

    always_ff @(posedge main_clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < VOICES; v++) begin
                freq_q[v]    <= '0;
                pw_q[v]      <= '0;
                wave_q[v]    <= '0;
                sync_q[v]    <= 1'b0;
                ringmod_q[v] <= 1'b0;
                acc_q[v]     <= '0;
                ovf_q[v]     <= 1'b0;
`ifdef TONE_GENERATOR_TDM_NOISE_EN
                lfsr_q[v]     <= 23'h7FFFFF;
                noise_en_q[v] <= 1'b0;
`endif
            end
            dout_q  <= '0;
            voice_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (cfg_wr) begin
                freq_q[cfg_voice]    <= cfg_freq;
                pw_q[cfg_voice]      <= cfg_pw;
                wave_q[cfg_voice]    <= cfg_wave[2:0];
                sync_q[cfg_voice]    <= cfg_sync;
                ringmod_q[cfg_voice] <= cfg_ringmod;
`ifdef TONE_GENERATOR_TDM_NOISE_EN
                noise_en_q[cfg_voice] <= cfg_wave[3];
`endif
            end
            if (busy) begin
                acc_q[idx_q] <= acc_d;
                ovf_q[idx_q] <= sum[A];
`ifdef TONE_GENERATOR_TDM_NOISE_EN
                lfsr_q[idx_q] <= lfsr_d;
`endif
                dout_q  <= sample_d;
                voice_q <= idx_q;
            end
            valid_q <= busy;
        end
    end

    assign dout       = dout_q;
    assign dout_voice = voice_q;
    assign dout_valid = valid_q;
endmodule
